// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the boot-time ROM loader and the computer top level.
//   - state_t   : loader FSM state encodings
//   - ROM_DEPTH : instruction ROM depth in 16-bit words
//   - ROM_AW    : instruction ROM address width (2**ROM_AW >= ROM_DEPTH)
package rom_loader_pkg;

  localparam int ROM_DEPTH = 32768;
  localparam int ROM_AW    = 15;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader
//   Boot stage that receives a big-endian program image as a valid/ready byte
//   stream, writes the 16-bit instruction words into the instruction ROM and
//   holds the CPU in reset until the trailing checksum byte has been verified.
//   Image: LEN_HI, LEN_LO, N x (HI, LO), CHK where CHK = sum of the 2N
//   instruction bytes mod 256.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   byte_data  : incoming image byte
//   byte_valid : byte_data valid this cycle
//   byte_ready : loader accepts a byte (transfer = valid && ready)
//   rom_we     : one-cycle ROM write strobe
//   rom_addr   : ROM write address (holds when rom_we = 0)
//   rom_data   : ROM write data
//   cpu_reset  : CPU reset, high until a good image is loaded
//   done       : image loaded and checksum matched
//   error      : image rejected (too long or checksum mismatch)
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = ROM_DEPTH,
  parameter int AW    = ROM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    byte_data,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [15:0]   rom_data,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  // 17 bits so that any 16-bit length can be compared against DEPTH.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t        state;
  logic [7:0]    len_hi;
  logic [15:0]   word_count;
  logic [AW-1:0] word_idx;
  logic [7:0]    hi_byte;
  logic [7:0]    checksum;

  logic          xfer;
  logic [16:0]   len_full;
  logic          last_word;

  assign xfer      = byte_valid && byte_ready;
  assign len_full  = {1'b0, len_hi, byte_data};
  // word_idx is the index of the word being completed by the current LO byte.
  assign last_word = ((17'(word_idx) + 17'd1) == 17'(word_count));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LEN_HI;
      len_hi     <= 8'h00;
      word_count <= 16'h0000;
      word_idx   <= '0;
      hi_byte    <= 8'h00;
      checksum   <= 8'h00;
      byte_ready <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= 16'h0000;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; ready stays high in every
      // receiving state and is dropped on entry to a terminal state.
      rom_we     <= 1'b0;
      byte_ready <= 1'b1;

      case (state)
        LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            word_count <= {len_hi, byte_data};
            if (len_full > DEPTH_W) begin
              state      <= ERROR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
            end else if (len_full == 17'd0) begin
              // Empty image: checksum is still zero, so CHK must be 0x00.
              state <= CHECK;
            end else begin
              state <= DATA_HI;
            end
          end
        end

        DATA_HI: begin
          if (xfer) begin
            hi_byte  <= byte_data;
            checksum <= checksum + byte_data;
            state    <= DATA_LO;
          end
        end

        DATA_LO: begin
          if (xfer) begin
            rom_we   <= 1'b1;
            rom_addr <= word_idx;
            rom_data <= {hi_byte, byte_data};
            checksum <= checksum + byte_data;
            word_idx <= word_idx + AW'(1);
            state    <= last_word ? CHECK : DATA_HI;
          end
        end

        CHECK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == checksum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        DONE: begin
          byte_ready <= 1'b0;
        end

        ERROR: begin
          byte_ready <= 1'b0;
        end

        default: begin
          state      <= ERROR;
          error      <= 1'b1;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Directed self-checking bench for rom_loader. Inputs change on the falling
//   edge, outputs are sampled on the falling edge; every ROM write is logged.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int AW = ROM_AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];
  logic          cur_is_lo = 1'b0;
  logic          lo_xfer_prev;

  always #5 clk = ~clk;

  rom_loader #(.DEPTH(ROM_DEPTH), .AW(ROM_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  // Remember whether the previous clock edge carried a LO-byte transfer.
  always @(posedge clk or posedge reset) begin
    if (reset) lo_xfer_prev <= 1'b0;
    else       lo_xfer_prev <= byte_valid && byte_ready && cur_is_lo;
  end

  // Write monitor: log each write and confirm it follows a LO transfer.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      checks++;
      if (lo_xfer_prev !== 1'b1) begin
        errors++;
        $display("FAIL we_without_lo: rom_we=1 addr=%0h but previous edge had no LO transfer", rom_addr);
      end
      wa.push_back(rom_addr);
      wd.push_back(rom_data);
      $display("write addr=%0h data=%04h", rom_addr, rom_data);
    end
  end

  task automatic do_reset();
    byte_valid = 1'b0;
    cur_is_lo  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
    @(negedge clk);
  endtask

  // Present one byte and hold it until the loader accepts it; returns on the
  // falling edge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input logic lo);
    int t;
    t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    cur_is_lo  = lo;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted, byte_ready=%b required 1", b, byte_ready);
      byte_valid = 1'b0;
      cur_is_lo  = 1'b0;
      return;
    end
    @(negedge clk);
    $display("byte %02h accepted lo=%0b", b, lo);
    byte_valid = 1'b0;
    cur_is_lo  = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img[$], input int max_gap);
    int n;
    logic lo;
    n = (img.size() >= 2) ? int'({img[0], img[1]}) : 0;
    for (int i = 0; i < img.size(); i++) begin
      lo = (i >= 2) && (i < 2 + 2 * n) && ((i % 2) == 1);
      send_byte(img[i], lo);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b addr=%0h data=%h cpu_reset=%b done=%b error=%b required 0 0 0 0 1 0 0",
               byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: byte_ready=%b required 0", byte_ready);
    end
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: byte_ready=%b cpu_reset=%b required 1 1", byte_ready, cpu_reset);
    end
  endtask

  task automatic test_two_word(input int max_gap, input string tag);
    logic [7:0] img[$];
    do_reset();
    img = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hFE};
    send_image(img, max_gap);
    checks++;
    if (wa.size() !== 2) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required 2", tag, wa.size());
    end else begin
      checks++;
      if (wa[0] !== 0 || wd[0] !== 16'h0002 || wa[1] !== 1 || wd[1] !== 16'hEC10) begin
        errors++;
        $display("FAIL %s_writes: got %0h=%04h %0h=%04h required 0=0002 1=ec10", tag, wa[0], wd[0], wa[1], wd[1]);
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: done=%b cpu_reset=%b error=%b ready=%b required 1 0 0 0",
               tag, done, cpu_reset, error, byte_ready);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] img[$];
    do_reset();
    img = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hFF};
    send_image(img, 0);
    checks++;
    if (wa.size() !== 2) begin
      errors++;
      $display("FAIL badchk_write_count: got %0d required 2", wa.size());
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL badchk_result: error=%b done=%b cpu_reset=%b ready=%b required 1 0 1 0",
               error, done, cpu_reset, byte_ready);
    end
  endtask

  task automatic test_length_limit();
    do_reset();
    send_byte(8'h80, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_result: error=%b done=%b cpu_reset=%b ready=%b required 1 0 1 0",
               error, done, cpu_reset, byte_ready);
    end
    // Bytes offered in the terminal state must be ignored.
    byte_data  = 8'h55;
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (wa.size() !== 0 || error !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_ignore: writes=%0d error=%b ready=%b required 0 1 0", wa.size(), error, byte_ready);
    end
    // Exactly DEPTH words is legal: the loader moves on to the data phase.
    do_reset();
    send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (error !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL depth_accepted: error=%b ready=%b required 0 1", error, byte_ready);
    end
  endtask

  task automatic test_zero_length();
    logic [7:0] img[$];
    do_reset();
    img = '{8'h00, 8'h00, 8'h00};
    send_image(img, 0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0 || wa.size() !== 0) begin
      errors++;
      $display("FAIL zero_ok: done=%b error=%b cpu_reset=%b writes=%0d required 1 0 0 0",
               done, error, cpu_reset, wa.size());
    end
    do_reset();
    img = '{8'h00, 8'h00, 8'h01};
    send_image(img, 0);
    checks++;
    if (done !== 1'b0 || error !== 1'b1 || cpu_reset !== 1'b1 || wa.size() !== 0) begin
      errors++;
      $display("FAIL zero_badchk: done=%b error=%b cpu_reset=%b writes=%0d required 0 1 1 0",
               done, error, cpu_reset, wa.size());
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] img[$];
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b1);
    checks++;
    if (rom_we !== 1'b1 || rom_data !== 16'h0002) begin
      errors++;
      $display("FAIL midload_write: rom_we=%b data=%04h required 1 0002", rom_we, rom_data);
    end
    // Assert reset between clock edges; outputs must clear with no edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: ready=%b we=%b addr=%0h data=%h cpu_reset=%b done=%b error=%b required 0 0 0 0 1 0 0",
               byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error);
    end
    @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
    @(negedge clk);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
    send_image(img, 0);
    checks++;
    if (wa.size() !== 1) begin
      errors++;
      $display("FAIL reload_write_count: got %0d required 1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 0 || wd[0] !== 16'h1234) begin
        errors++;
        $display("FAIL reload_write: got %0h=%04h required 0=1234", wa[0], wd[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reload_result: done=%b cpu_reset=%b error=%b required 1 0 0", done, cpu_reset, error);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_two_word(0, "b2b");
    test_bad_checksum();
    test_length_limit();
    test_zero_length();
    test_two_word(5, "gaps");
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
